mux_arb_rr: RTL and testbench
=============================

Name: mux_arb_rr

Overview:
- Parametrised N-channel, W-bit stream multiplexer: next generation of the team's combinational wide mux.
- Adds a valid/ready handshake per input and on the output, and a registered output stage.
- Two selection modes: round-robin arbitration among valid inputs, or fixed software select.
- Sits between multiple bus masters or peripheral data sources and a single downstream consumer, for example the CPU read-return path or a UART/VGA source merge.

Parameters:
- WIDTH, 32, data width per channel in bits (>=1).
- NCH, 16, number of input channels (2..64).
- SELW, $clog2(NCH), channel-index width; derived localparam, not overridable.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_data  in  NCH*WIDTH  flattened inputs; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  in  NCH  per-channel valid.
- in_ready  out  NCH  per-channel ready; at most one bit high in any cycle (one-hot or zero).
- mode  in  1  0 = round-robin, 1 = fixed select.
- sel  in  SELW  channel used when mode=1; values >= NCH select nothing.
- out_data  out  WIDTH  registered output data.
- out_ch  out  SELW  index of the channel that supplied out_data.
- out_valid  out  1  output register holds a beat.
- out_ready  in  1  downstream accepts the beat.

Behaviour:
- Reset (async assert, sync-safe release):
  - out_valid=0, out_data=0, out_ch=0.
  - Round-robin pointer = NCH-1, so the first search starts at channel 0.
  - in_ready is combinational and therefore 0 while out_valid=0 and no input is valid.
- Load condition: load = !out_valid | out_ready.
- Grant, computed combinationally each cycle:
  - mode=0: first valid channel searching upward from pointer+1, with modulo NCH wrap-around.
  - mode=1: channel sel if in_valid[sel] and sel<NCH; otherwise no grant.
- Input ready: in_ready[g] = load & grant_valid. All other in_ready bits are 0.
  - in_ready never depends on in_valid of the same channel beyond the grant.
- Transfer on input g (in_valid[g] & in_ready[g]):
  - Next edge: out_data <= in_data[g], out_ch <= g, out_valid <= 1.
  - mode=0 only: pointer <= g.
- Output side:
  - Output accepted with no new grant: out_valid <= 0. out_data and out_ch hold their last value.
  - Accepted and a new grant on the same cycle: the register reloads back-to-back. Full throughput is 1 beat/cycle.
- Backpressure: while out_valid & !out_ready, out_data, out_ch and out_valid are held stable and all in_ready=0.
- Latency: input transfer to out_valid is exactly 1 cycle.
- Fairness: in mode 0 with all channels continuously valid and out_ready=1, grants cycle 0,1,...,NCH-1,0,...
  - Any channel waits at most NCH-1 grants.
- The pointer advances only on an accepted input transfer. An idle cycle or mode=1 leaves it unchanged.
- mode/sel changes take effect in the same cycle's grant. A beat already in the output register is unaffected.
- Reset mid-transfer: the output beat is discarded (out_valid=0 immediately) and the pointer returns to NCH-1.

Optional Feature:
- Macro: MUX_ARB_LOCK_EN.
- Defined:
  - Adds ports in_last [NCH] (input) and out_last [1] (output, registered alongside out_data, reset 0).
  - Once a channel is granted a beat with in_last=0, the grant stays locked to that channel, ignoring other valids and mode/sel, until its beat with in_last=1 is transferred.
  - The pointer updates at unlock.
- Undefined: no in_last/out_last ports; every beat is arbitrated independently.

Decomposition:
- Package mux_arb_pkg:
  - Constants MUX_WIDTH_DEF=32 and MUX_NCH_DEF=16.
  - Mode encodings MODE_RR=1'b0 and MODE_FIXED=1'b1.
  - A function computing the rotated first-set index.
- One sub-module, rr_arbiter:
  - Inputs: req[NCH], ptr[SELW].
  - Outputs: grant_onehot[NCH], grant_idx[SELW], grant_valid.
  - Purely combinational. The top level owns the pointer register, output register and lock state.

Test Plan:
- Reset check: assert rst_n=0 mid-stream with out_valid=1 -> out_valid/out_data/out_ch go to 0 immediately. After release, with in_valid=16'hFFFF, the first grant is ch0.
- Round-robin, all channels valid, in_data[i]=32'hA000_0000+i, out_ready=1 -> out_ch sequence 0,1,2,...,15,0 on consecutive cycles, with out_data matching each channel.
- Sparse requests, in_valid=16'h8011, pointer after ch4 -> next grants 15, then 0 (wrap-around), then 4.
- Backpressure: out_ready=0 for 5 cycles with a beat held -> out_data stable and in_ready=0 throughout. out_ready=1 -> the beat is accepted and the next beat loads on the same edge.
- Fixed mode: mode=1, sel=5, in_valid=16'h0021 -> only ch5 transfers, every cycle. sel=5'h1F at NCH=16 and SELW=4 is not representable, so at NCH=20 use sel=25 -> no grant, and out_valid drops after drain.
- MUX_ARB_LOCK_EN: ch2 sends 3 beats (in_last=0,0,1) while ch3 is valid -> out_ch=2,2,2 then 3, with out_last=1 on the third beat only.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// ---------------------------------------------------------------------------
// mux_arb_pkg
//   Shared definitions for the mux_arb_rr stream multiplexer:
//   - default parameter values (MUX_WIDTH_DEF, MUX_NCH_DEF)
//   - selection-mode encoding (MODE_RR / MODE_FIXED)
//   - rr_first_set(): rotated first-set search used by the round-robin arbiter
// ---------------------------------------------------------------------------
package mux_arb_pkg;

  localparam int MUX_WIDTH_DEF = 32;
  localparam int MUX_NCH_DEF   = 16;
  localparam int MUX_NCH_MAX   = 64;

  typedef enum logic {
    MODE_RR    = 1'b0,
    MODE_FIXED = 1'b1
  } mux_mode_e;

  // Returns the index of the first set bit of req[nch-1:0], searching upward
  // from ptr+1 and wrapping modulo nch. Returns -1 when no bit is set.
  // ptr is always in 0..nch-1, so a single conditional subtraction wraps.
  function automatic int rr_first_set(input logic [MUX_NCH_MAX-1:0] req,
                                      input int nch,
                                      input int ptr);
    int idx;
    int found;
    found = -1;
    for (int k = 0; k < MUX_NCH_MAX; k++) begin
      if (k < nch && found < 0) begin
        idx = ptr + 1 + k;
        if (idx >= nch) idx = idx - nch;
        if (req[idx]) found = idx;
      end
    end
    return found;
  endfunction

endpackage

// File: rtl/mux_arb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin arbiter. Grants the first requester
//   above ptr (wrapping). The pointer register lives in the parent.
//
//   req          in  NCH   request vector
//   ptr          in  SELW  index of the most recently granted channel
//   grant_onehot out NCH   one-hot grant (zero when nothing requests)
//   grant_idx    out SELW  binary index of the grant (0 when no grant)
//   grant_valid  out 1     at least one request is present
// ---------------------------------------------------------------------------
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int NCH  = MUX_NCH_DEF,
  localparam int SELW = $clog2(NCH)
) (
  input  logic [NCH-1:0]  req,
  input  logic [SELW-1:0] ptr,
  output logic [NCH-1:0]  grant_onehot,
  output logic [SELW-1:0] grant_idx,
  output logic            grant_valid
);

  int first_idx;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment; a path that skips an assignment infers a latch.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    grant_valid  = 1'b0;
    first_idx    = rr_first_set(MUX_NCH_MAX'(req), NCH, int'(ptr));
    if (first_idx >= 0) begin
      grant_valid = 1'b1;
      grant_idx   = SELW'(first_idx);
      for (int i = 0; i < NCH; i++) begin
        grant_onehot[i] = (first_idx == i);
      end
    end
  end

endmodule

// File: rtl/mux_arb_rr.sv
// ---------------------------------------------------------------------------
// mux_arb_rr
//   N-channel, W-bit stream multiplexer with valid/ready handshakes on every
//   input and on the output, and a registered output stage. Selection is
//   either round-robin among valid inputs (mode=0) or a fixed channel given
//   by sel (mode=1; sel >= NCH selects nothing).
//
//   clk        in   1          rising-edge clock
//   rst_n      in   1          asynchronous active-low reset
//   in_data    in   NCH*WIDTH  channel i at [i*WIDTH +: WIDTH]
//   in_valid   in   NCH        per-channel valid
//   in_ready   out  NCH        per-channel ready, one-hot or zero
//   mode       in   1          0 = round-robin, 1 = fixed select
//   sel        in   SELW       channel used when mode=1
//   out_data   out  WIDTH      registered output data
//   out_ch     out  SELW       channel that supplied out_data
//   out_valid  out  1          output register holds a beat
//   out_ready  in   1          downstream accepts the beat
//
//   Optional feature, macro MUX_ARB_LOCK_EN: adds in_last[NCH] and out_last.
//   A beat transferred with in_last=0 locks the grant to its channel until
//   that channel's in_last=1 beat transfers; the round-robin pointer moves
//   only at unlock. Without the macro every beat is a one-beat packet.
// ---------------------------------------------------------------------------
module mux_arb_rr
  import mux_arb_pkg::*;
#(
  parameter  int WIDTH = MUX_WIDTH_DEF,
  parameter  int NCH   = MUX_NCH_DEF,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_ch,
  output logic                 out_valid,
  input  logic                 out_ready
`ifdef MUX_ARB_LOCK_EN
  ,
  input  logic [NCH-1:0]       in_last,
  output logic                 out_last
`endif
);

  // Per-channel end-of-packet flag; without the lock feature every beat ends
  // its packet, so the lock never engages.
  logic [NCH-1:0] last_w;
`ifdef MUX_ARB_LOCK_EN
  assign last_w = in_last;
`else
  assign last_w = '1;
`endif

  // State registers
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [SELW-1:0]  out_ch_q,    out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             out_last_q,  out_last_d;
  logic [SELW-1:0]  ptr_q,       ptr_d;
  logic             lock_q,      lock_d;
  logic [SELW-1:0]  lock_ch_q,   lock_ch_d;

  // Round-robin candidate
  logic [NCH-1:0]  rr_onehot;
  logic [SELW-1:0] rr_idx;
  logic            rr_valid;

  rr_arbiter #(.NCH(NCH)) u_rr (
    .req          (in_valid),
    .ptr          (ptr_q),
    .grant_onehot (rr_onehot),
    .grant_idx    (rr_idx),
    .grant_valid  (rr_valid)
  );

  // Final grant
  logic [NCH-1:0]   grant_oh;
  logic [SELW-1:0]  grant_idx;
  logic             grant_valid;
  logic [SELW-1:0]  target_ch;
  logic [WIDTH-1:0] grant_data;
  logic             grant_last;
  logic             load;
  logic             xfer;

  // A locked packet overrides both modes; otherwise mode picks the source.
  // In the directed case the loop compare means a sel >= NCH matches no
  // channel and yields no grant.
  always_comb begin
    grant_oh    = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    target_ch   = lock_q ? lock_ch_q : sel;
    if (!lock_q && mode == MODE_RR) begin
      grant_oh    = rr_onehot;
      grant_idx   = rr_idx;
      grant_valid = rr_valid;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (SELW'(i) == target_ch && in_valid[i]) begin
          grant_oh[i] = 1'b1;
          grant_idx   = target_ch;
          grant_valid = 1'b1;
        end
      end
    end
  end

  // One-hot AND-OR data selection.
  always_comb begin
    grant_data = '0;
    grant_last = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      grant_data = grant_data | (in_data[i*WIDTH +: WIDTH] & {WIDTH{grant_oh[i]}});
      grant_last = grant_last | (last_w[i] & grant_oh[i]);
    end
  end

  // The output register can take a new beat when empty or being drained.
  assign load     = !out_valid_q || out_ready;
  assign xfer     = load && grant_valid;
  assign in_ready = load ? grant_oh : '0;

  always_comb begin
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    lock_ch_d   = lock_ch_q;

    if (load) begin
      out_valid_d = grant_valid;
      if (grant_valid) begin
        out_data_d = grant_data;
        out_ch_d   = grant_idx;
        out_last_d = grant_last;
      end
    end

    if (xfer) begin
      lock_d    = !grant_last;
      lock_ch_d = grant_idx;
      // Pointer moves at packet end only (every beat without the lock).
      if (grant_last && mode == MODE_RR) begin
        ptr_d = grant_idx;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      ptr_q       <= SELW'(NCH - 1);
      lock_q      <= 1'b0;
      lock_ch_q   <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      lock_ch_q   <= lock_ch_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;
`ifdef MUX_ARB_LOCK_EN
  assign out_last  = out_last_q;
`else
  // Without the lock feature out_last_q is never observed.
  logic unused_last;
  assign unused_last = out_last_q;
`endif

endmodule

// File: tb/tb_mux_arb_rr.sv
// ---------------------------------------------------------------------------
// tb_mux_arb_rr
//   Self-checking bench for mux_arb_rr (NCH=16, WIDTH=32) plus a second
//   NCH=20 instance for the out-of-range sel case. A behavioural model keeps
//   the round-robin pointer as an integer and searches with modulo
//   arithmetic; directed steps follow the test plan, then random traffic.
//   Honors MUX_ARB_LOCK_EN for the in_last/out_last ports.
// ---------------------------------------------------------------------------
module tb_mux_arb_rr;

  localparam int WIDTH = 32;
  localparam int NCH   = 16;
  localparam int SELW  = $clog2(NCH);
  localparam int W20   = 8;
  localparam int N20   = 20;
  localparam int S20   = $clog2(N20);

  logic                 clk;
  logic                 rst_n;
  logic [NCH*WIDTH-1:0] in_data;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic                 mode;
  logic [SELW-1:0]      sel;
  logic [WIDTH-1:0]     out_data;
  logic [SELW-1:0]      out_ch;
  logic                 out_valid;
  logic                 out_ready;
  logic [NCH-1:0]       last_v;

  logic [N20*W20-1:0]   in_data20;
  logic [N20-1:0]       in_valid20;
  logic [N20-1:0]       in_ready20;
  logic                 mode20;
  logic [S20-1:0]       sel20;
  logic [W20-1:0]       out_data20;
  logic [S20-1:0]       out_ch20;
  logic                 out_valid20;
  logic                 out_ready20;

`ifdef MUX_ARB_LOCK_EN
  logic                 out_last;
  logic                 out_last20;
`endif

  mux_arb_rr #(.WIDTH(WIDTH), .NCH(NCH)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out_data  (out_data),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef MUX_ARB_LOCK_EN
    ,
    .in_last   (last_v),
    .out_last  (out_last)
`endif
  );

  mux_arb_rr #(.WIDTH(W20), .NCH(N20)) u_dut20 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data20),
    .in_valid  (in_valid20),
    .in_ready  (in_ready20),
    .mode      (mode20),
    .sel       (sel20),
    .out_data  (out_data20),
    .out_ch    (out_ch20),
    .out_valid (out_valid20),
    .out_ready (out_ready20)
`ifdef MUX_ARB_LOCK_EN
    ,
    .in_last   ({N20{1'b1}}),
    .out_last  (out_last20)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int         m_ptr;
  bit         m_valid;
  bit [31:0]  m_data;
  int         m_ch;
  bit         m_last;
  bit         m_lock;
  int         m_lock_ch;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr     = NCH - 1;
    m_valid   = 1'b0;
    m_data    = '0;
    m_ch      = 0;
    m_last    = 1'b0;
    m_lock    = 1'b0;
    m_lock_ch = 0;
  endtask

  // Grant according to the rules: locked channel, else round-robin search
  // from pointer+1 modulo NCH, else the fixed channel if in range and valid.
  task automatic model_grant(output int g, output bit gv);
    int c;
    g  = 0;
    gv = 1'b0;
    if (m_lock) begin
      if (in_valid[m_lock_ch]) begin g = m_lock_ch; gv = 1'b1; end
    end else if (mode == 1'b0) begin
      for (int k = 1; k <= NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (!gv && in_valid[c]) begin g = c; gv = 1'b1; end
      end
    end else if (int'(sel) < NCH && in_valid[sel]) begin
      g  = int'(sel);
      gv = 1'b1;
    end
  endtask

  // One clock cycle: check in_ready before the edge, update the model at the
  // edge, check registered outputs at the following falling edge.
  task automatic step();
    int g;
    bit gv;
    bit ld;
    model_grant(g, gv);
    ld = !m_valid || out_ready;
    #1;
    check("in_ready", 64'(in_ready), (ld && gv) ? (64'd1 << g) : 64'd0);
    @(posedge clk);
    if (ld) begin
      m_valid = gv;
      if (gv) begin
        m_data    = in_data[g*WIDTH +: WIDTH];
        m_ch      = g;
        m_last    = last_v[g];
        m_lock    = !last_v[g];
        m_lock_ch = g;
        if (last_v[g] && mode == 1'b0) m_ptr = g;
      end
    end
    @(negedge clk);
    check("out_valid", 64'(out_valid), 64'(m_valid));
    check("out_data",  64'(out_data),  64'(m_data));
    check("out_ch",    64'(out_ch),    64'(m_ch));
`ifdef MUX_ARB_LOCK_EN
    check("out_last",  64'(out_last),  64'(m_last));
`endif
  endtask

  initial begin
    rst_n       = 1'b0;
    in_data     = '0;
    in_valid    = '0;
    mode        = 1'b0;
    sel         = '0;
    out_ready   = 1'b1;
    last_v      = '1;
    in_valid20  = '0;
    mode20      = 1'b0;
    sel20       = '0;
    out_ready20 = 1'b1;
    for (int i = 0; i < N20; i++) in_data20[i*W20 +: W20] = W20'(8'h30 + i);
    model_reset();

    // Reset values
    repeat (2) @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_data",  64'(out_data),  64'd0);
    check("rst_out_ch",    64'(out_ch),    64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid20", 64'(out_valid20), 64'd0);
    rst_n = 1'b1;

    // NCH=20: sel=3 transfers, sel=25 grants nothing and the output drains
    mode20     = 1'b1;
    sel20      = 5'd3;
    in_valid20 = '1;
    #1 check("d20_ready_sel3", 64'(in_ready20), 64'h8);
    step();
    check("d20_valid_sel3", 64'(out_valid20), 64'd1);
    check("d20_ch_sel3",    64'(out_ch20),    64'd3);
    check("d20_data_sel3",  64'(out_data20),  64'h33);
    sel20 = 5'd25;
    #1 check("d20_ready_sel25", 64'(in_ready20), 64'd0);
    step();
    check("d20_valid_drain", 64'(out_valid20), 64'd0);
    check("d20_ch_hold",     64'(out_ch20),    64'd3);
    step();
    check("d20_valid_idle",  64'(out_valid20), 64'd0);
    in_valid20 = '0;

    // Round-robin, all channels valid: 0,1,...,15,0
    for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = 32'hA000_0000 + 32'(i);
    in_valid = '1;
    for (int k = 0; k <= NCH; k++) begin
      step();
      check("rr_seq_ch",   64'(out_ch),   64'(k % NCH));
      check("rr_seq_data", 64'(out_data), 64'(32'hA000_0000 + 32'(k % NCH)));
    end

    // Mid-stream reset clears the output immediately
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(out_valid), 64'd0);
    check("mid_rst_data",  64'(out_data),  64'd0);
    check("mid_rst_ch",    64'(out_ch),    64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    check("post_rst_first_ch", 64'(out_ch), 64'd0);

    // Sparse requests with wrap-around
    in_valid = 16'h0010;
    step();
    check("sparse_ch4", 64'(out_ch), 64'd4);
    in_valid = 16'h8011;
    step();
    check("sparse_ch15", 64'(out_ch), 64'd15);
    step();
    check("sparse_wrap_ch0", 64'(out_ch), 64'd0);
    step();
    check("sparse_ch4_again", 64'(out_ch), 64'd4);

    // Backpressure for 5 cycles, then back-to-back reload
    in_valid  = '1;
    out_ready = 1'b0;
    repeat (5) step();
    check("bp_hold_ch", 64'(out_ch), 64'd4);
    out_ready = 1'b1;
    step();
    check("bp_reload_ch", 64'(out_ch), 64'd5);

    // Fixed mode, sel=5
    mode     = 1'b1;
    sel      = 4'd5;
    in_valid = 16'h0021;
    repeat (3) begin
      step();
      check("fixed_ch5", 64'(out_ch), 64'd5);
    end
    mode = 1'b0;

`ifdef MUX_ARB_LOCK_EN
    // Packet lock: ch2 sends three beats while ch3 waits
    rst_n = 1'b0;
    #1 model_reset();
    @(negedge clk);
    rst_n     = 1'b1;
    in_valid  = 16'h000C;
    last_v    = '1;
    last_v[2] = 1'b0;
    step();
    check("lock_b0_ch", 64'(out_ch), 64'd2);
    step();
    check("lock_b1_ch", 64'(out_ch), 64'd2);
    last_v[2] = 1'b1;
    step();
    check("lock_b2_ch",   64'(out_ch),   64'd2);
    check("lock_b2_last", 64'(out_last), 64'd1);
    in_valid = 16'h0008;
    step();
    check("lock_next_ch3", 64'(out_ch), 64'd3);
`endif

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < NCH; i++) in_data[i*WIDTH +: WIDTH] = $urandom;
      in_valid  = NCH'($urandom & $urandom);
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(9) == 0) mode = ~mode;
      sel = SELW'($urandom);
`ifdef MUX_ARB_LOCK_EN
      last_v = NCH'($urandom | $urandom);
`endif
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
